// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit
// Purpose  : RV32I execute stage; single-cycle ALU ops plus a 1-bit/cycle
//            serial shifter behind a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam logic [3:0] c_op_add   = 4'd0;
   localparam logic [3:0] c_op_sub   = 4'd1;
   localparam logic [3:0] c_op_and   = 4'd2;
   localparam logic [3:0] c_op_or    = 4'd3;
   localparam logic [3:0] c_op_xor   = 4'd4;
   localparam logic [3:0] c_op_slt   = 4'd5;
   localparam logic [3:0] c_op_sltu  = 4'd6;
   localparam logic [3:0] c_op_sll   = 4'd7;
   localparam logic [3:0] c_op_srl   = 4'd8;
   localparam logic [3:0] c_op_sra   = 4'd9;
   localparam logic [3:0] c_op_passb = 4'd10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] w_alu_result;
   logic [XLEN-1:0] w_acc_shifted;
   logic [4:0]      r_cnt;
   logic [3:0]      r_op;
   logic            r_done;
   logic            r_zero;
   logic            w_is_shift;
   logic            w_accept;

   assign w_is_shift = (alu_op == c_op_sll) || (alu_op == c_op_srl) || (alu_op == c_op_sra);
   assign w_accept   = start && (r_state == ST_IDLE);

   always_comb begin
      w_alu_result = '0;
      case (alu_op)
         c_op_add:   w_alu_result = a + b;
         c_op_sub:   w_alu_result = a - b;
         c_op_and:   w_alu_result = a & b;
         c_op_or:    w_alu_result = a | b;
         c_op_xor:   w_alu_result = a ^ b;
         c_op_slt:   w_alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         c_op_sltu:  w_alu_result = {{(XLEN-1){1'b0}}, (a < b)};
         c_op_passb: w_alu_result = b;
         default:    w_alu_result = '0;
      endcase
   end

   // One shift step per cycle; SRA replicates the sign bit into the vacated MSB.
   always_comb begin
      w_acc_shifted = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
      if (r_op == c_op_sll) begin
         w_acc_shifted = {r_acc[XLEN-2:0], 1'b0};
      end else if (r_op == c_op_srl) begin
         w_acc_shifted = {1'b0, r_acc[XLEN-1:1]};
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept && w_is_shift) w_state_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == 5'd0) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_accept && w_is_shift) begin
               r_acc <= a;
               r_cnt <= b[4:0];
               r_op  <= alu_op;
            end else if (w_accept) begin
               r_result <= w_alu_result;
               r_zero   <= (w_alu_result == '0);
               r_done   <= 1'b1;
            end
         end else if (r_cnt != 5'd0) begin
            r_acc <= w_acc_shifted;
            r_cnt <= r_cnt - 5'd1;
         end else begin
            r_result <= r_acc;
            r_zero   <= (r_acc == '0);
            r_done   <= 1'b1;
         end
      end
   end

   assign busy   = (r_state == ST_SHIFT);
   assign done   = r_done;
   assign result = r_result;
   assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_unit
// Purpose  : Self-checking bench for exec_unit against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_exec_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  alu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   int n_checks = 0;
   int n_errors = 0;

   exec_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .alu_op (alu_op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
      logic signed [31:0] sx;
      int sh;
      sx = x;
      sh = int'(y[4:0]);
      case (op)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6:    return (x < y) ? 32'd1 : 32'd0;
         4'd7:    return x << sh;
         4'd8:    return x >> sh;
         4'd9:    return sx >>> sh;
         4'd10:   return y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit is_shift(input logic [3:0] op);
      return (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
   endfunction

   // Issue one op, scramble inputs after acceptance, then check latency,
   // busy duration and the completed result.
   task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
      logic [31:0] exp;
      int exp_lat;
      int lat;
      int busy_cnt;
      exp     = model(op, x, y);
      exp_lat = is_shift(op) ? int'(y[4:0]) + 2 : 1;
      @(negedge clk);
      start  = 1'b1;
      alu_op = op;
      a      = x;
      b      = y;
      @(negedge clk);
      start    = 1'b0;
      alu_op   = 4'($urandom_range(0, 15));
      a        = $urandom;
      b        = $urandom;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy_cycles"}, busy_cnt, is_shift(op) ? exp_lat - 1 : 0);
      check({tag, " result"}, result, exp);
      check({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
      check({tag, " busy_with_done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  op;
      logic [31:0] prev_exp;

      rst    = 1'b1;
      start  = 1'b0;
      alu_op = 4'd0;
      a      = 32'd0;
      b      = 32'd0;
      #1;
      check("rst result", result, 32'd0);
      check("rst zero", {31'd0, zero}, 32'd1);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("idle done_count", cnt, 0);
      check("idle result", result, 32'd0);

      do_op(4'd0, 32'd5, 32'd7, "add_5_7");
      do_op(4'd1, 32'd3, 32'd5, "sub_3_5");
      do_op(4'd1, 32'd9, 32'd9, "sub_9_9");
      do_op(4'd5, 32'hFFFF_FFFF, 32'd1, "slt_neg");
      do_op(4'd6, 32'hFFFF_FFFF, 32'd1, "sltu_big");
      do_op(4'd9, 32'h8000_0000, 32'h0000_0024, "sra_4");
      do_op(4'd8, 32'h8000_0000, 32'h0000_0024, "srl_4");
      do_op(4'd7, 32'h0000_0001, 32'd0, "sll_0");
      do_op(4'd7, 32'h0000_0001, 32'd31, "sll_31");
      do_op(4'd10, 32'h1234_5678, 32'hCAFE_F00D, "passb");
      do_op(4'd13, 32'h1234_5678, 32'hCAFE_F00D, "op13");

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = $urandom;
         y  = $urandom;
         if (i % 5 == 0) y = x;
         do_op(op, x, y, $sformatf("rand%0d_op%0d", i, op));
      end

      // Back-to-back single-cycle ops with start held high.
      @(negedge clk);
      prev_exp = 32'd0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            check($sformatf("b2b%0d done", i), {31'd0, done}, 32'd1);
            check($sformatf("b2b%0d result", i), result, prev_exp);
         end
         op = 4'($urandom_range(0, 6));
         x  = $urandom;
         y  = $urandom;
         start    = 1'b1;
         alu_op   = op;
         a        = x;
         b        = y;
         prev_exp = model(op, x, y);
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b last done", {31'd0, done}, 32'd1);
      check("b2b last result", result, prev_exp);

      // Start while busy is dropped; start in the done cycle is accepted.
      x = $urandom | 32'h1;
      start  = 1'b1;
      alu_op = 4'd7;
      a      = x;
      b      = 32'd8;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("swb busy", {31'd0, busy}, 32'd1);
      start  = 1'b1;
      alu_op = 4'd0;
      a      = 32'd100;
      b      = 32'd23;
      @(negedge clk);
      start = 1'b0;
      cnt   = 4;
      while (!done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check("swb sll latency", cnt, 10);
      check("swb sll result", result, x << 8);
      start  = 1'b1;
      alu_op = 4'd0;
      a      = 32'd40;
      b      = 32'd2;
      @(negedge clk);
      start = 1'b0;
      check("swb add done", {31'd0, done}, 32'd1);
      check("swb add result", result, 32'd42);
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("swb extra_done", cnt, 0);

      // Reset in the middle of a 20-bit shift.
      do_op(4'd0, 32'd3, 32'd4, "pre_rst_add");
      start  = 1'b1;
      alu_op = 4'd8;
      a      = 32'hFFFF_0000;
      b      = 32'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("mid busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst result", result, 32'd0);
      check("mid_rst zero", {31'd0, zero}, 32'd1);
      check("mid_rst busy", {31'd0, busy}, 32'd0);
      check("mid_rst done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      start  = 1'b1;
      alu_op = 4'd0;
      a      = 32'd1;
      b      = 32'd1;
      @(negedge clk);
      start = 1'b0;
      check("post_rst done", {31'd0, done}, 32'd1);
      check("post_rst result", result, 32'd2);
      check("post_rst zero", {31'd0, zero}, 32'd0);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("post_rst no_done", cnt, 0);
      check("post_rst hold", result, 32'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
